// File: rtl/inst_buffer_pkg.sv
// Shared types and sizing for the predecode->decode instruction buffer.
package inst_buffer_pkg;

    localparam int unsigned BLOCK_INST_SIZE = 8;
    localparam int unsigned DECODE_WIDTH    = 4;
    localparam int unsigned DEPTH           = 32;
    localparam int unsigned OFFSET_W        = 4;
    localparam int unsigned FSQ_WIDTH       = 5;

    localparam int unsigned NUM_W  = $clog2(BLOCK_INST_SIZE) + 1;
    localparam int unsigned PTR_W  = $clog2(DEPTH) + 1;
    localparam int unsigned BANK_W = $clog2(BLOCK_INST_SIZE);
    localparam int unsigned ROWS   = DEPTH / BLOCK_INST_SIZE;
    localparam int unsigned ROW_W  = $clog2(ROWS);

    typedef struct packed {
        logic [31:0]          inst;
        logic [OFFSET_W-1:0]  offset;
        logic [FSQ_WIDTH-1:0] fsq_idx;
        logic                 ipf;
        logic                 iam;
    } ibuf_entry_t;

    localparam int unsigned ENTRY_W = $bits(ibuf_entry_t);

    // Pointer with one wrap bit above the entry index.
    typedef logic [PTR_W-1:0] ibuf_ptr_t;

endpackage

// File: rtl/inst_buffer_bank.sv
// One storage bank of the instruction buffer: single write port, single async read port.
module inst_buffer_bank
    import inst_buffer_pkg::*;
(
    input  logic               clk,
    input  logic               we,
    input  logic [ROW_W-1:0]   waddr,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic [ROW_W-1:0]   raddr,
    output logic [ENTRY_W-1:0] rdata
);

    logic [ENTRY_W-1:0] mem [ROWS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_buffer.sv
// Circular instruction FIFO between predecode and decode; entries are interleaved across
// BLOCK_INST_SIZE banks so a full fetch block lands with one write per bank.
module inst_buffer
    import inst_buffer_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic [BLOCK_INST_SIZE-1:0]      in_en,
    input  logic [NUM_W-1:0]                in_num,
    input  logic [BLOCK_INST_SIZE*32-1:0]   in_inst,
    input  logic [BLOCK_INST_SIZE*OFFSET_W-1:0] in_offset,
    input  logic [FSQ_WIDTH-1:0]            in_fsq_idx,
    input  logic [BLOCK_INST_SIZE-1:0]      in_ipf,
    input  logic                            in_iam,
    output logic                            full,
    output logic [DECODE_WIDTH-1:0]         out_valid,
    input  logic                            out_ready,
    output logic [DECODE_WIDTH*32-1:0]      out_inst,
    output logic [DECODE_WIDTH*OFFSET_W-1:0] out_offset,
    output logic [DECODE_WIDTH*FSQ_WIDTH-1:0] out_fsq_idx,
    output logic [DECODE_WIDTH-1:0]         out_ipf,
    output logic [DECODE_WIDTH-1:0]         out_iam
);

    ibuf_ptr_t          head, tail, count, head_next, tail_next, count_next;
    logic               wr_en, rd_en;
    logic [NUM_W-1:0]   rd_num, wr_n, rd_n;
    logic [BANK_W-1:0]  head_bank, tail_bank;

    logic [ENTRY_W-1:0] bank_wdata [BLOCK_INST_SIZE];
    logic [ENTRY_W-1:0] bank_rdata [BLOCK_INST_SIZE];
    logic [ROW_W-1:0]   bank_waddr [BLOCK_INST_SIZE];
    logic [ROW_W-1:0]   bank_raddr [BLOCK_INST_SIZE];
    logic [BLOCK_INST_SIZE-1:0] bank_we;

    assign count     = tail - head;
    assign head_bank = head[BANK_W-1:0];
    assign tail_bank = tail[BANK_W-1:0];

    assign wr_en  = (|in_en) && !full && !flush;
    assign rd_en  = out_ready && !flush;
    assign rd_num = (count > PTR_W'(DECODE_WIDTH)) ? NUM_W'(DECODE_WIDTH) : NUM_W'(count);
    assign wr_n   = wr_en ? in_num : '0;
    assign rd_n   = rd_en ? rd_num : '0;

    assign head_next  = head + PTR_W'(rd_n);
    assign tail_next  = tail + PTR_W'(wr_n);
    assign count_next = tail_next - head_next;

    // Flush shares the reset path: both leave an empty buffer on the next cycle.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            head <= '0;
            tail <= '0;
            full <= 1'b0;
        end else begin
            head <= head_next;
            tail <= tail_next;
            full <= count_next > PTR_W'(DEPTH - BLOCK_INST_SIZE);
        end
    end

    // Write rotation: bank b receives the slot that maps onto it from tail; read rotation mirrors it from head.
    for (genvar b = 0; b < BLOCK_INST_SIZE; b++) begin : g_bank
        logic [BANK_W-1:0] wslot, rslot;
        ibuf_entry_t       wr_ent;

        assign wslot = BANK_W'(b) - tail_bank;
        assign rslot = BANK_W'(b) - head_bank;

        assign wr_ent.inst    = in_inst[wslot*32 +: 32];
        assign wr_ent.offset  = in_offset[wslot*OFFSET_W +: OFFSET_W];
        assign wr_ent.fsq_idx = in_fsq_idx;
        assign wr_ent.ipf     = in_ipf[wslot];
        assign wr_ent.iam     = in_iam;

        assign bank_we[b]    = wr_en && (NUM_W'(wslot) < in_num);
        assign bank_wdata[b] = wr_ent;
        assign bank_waddr[b] = ROW_W'((tail + PTR_W'(wslot)) >> BANK_W);
        assign bank_raddr[b] = ROW_W'((head + PTR_W'(rslot)) >> BANK_W);

        inst_buffer_bank u_bank (
            .clk   (clk),
            .we    (bank_we[b]),
            .waddr (bank_waddr[b]),
            .wdata (bank_wdata[b]),
            .raddr (bank_raddr[b]),
            .rdata (bank_rdata[b])
        );
    end

    for (genvar j = 0; j < DECODE_WIDTH; j++) begin : g_out
        ibuf_entry_t rd_ent;

        assign rd_ent       = bank_rdata[head_bank + BANK_W'(j)];
        assign out_valid[j] = PTR_W'(j) < count;

        assign out_inst[j*32 +: 32]                = out_valid[j] ? rd_ent.inst : '0;
        assign out_offset[j*OFFSET_W +: OFFSET_W]  = out_valid[j] ? rd_ent.offset : '0;
        assign out_fsq_idx[j*FSQ_WIDTH +: FSQ_WIDTH] = out_valid[j] ? rd_ent.fsq_idx : '0;
        assign out_ipf[j] = out_valid[j] && rd_ent.ipf;
        assign out_iam[j] = out_valid[j] && rd_ent.iam;
    end

    // Producer protocol checks.
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (int'(in_num) == $countones(in_en));
            assert ((in_en & (in_en + BLOCK_INST_SIZE'(1))) == '0);
            assert (count <= PTR_W'(DEPTH));
        end
    end

endmodule
